// File: rtl/surf_frame_arbiter_if.sv
// rtl/surf_frame_arbiter_if.sv - merged SURF readout streams: seven inputs plus one output
interface surf_frame_arbiter_if #(
  parameter int NSURF = 7
);
  logic [8*NSURF-1:0] s_tdata;
  logic [NSURF-1:0]   s_tvalid;
  logic [NSURF-1:0]   s_tlast;
  logic [NSURF-1:0]   s_tready;
  logic [7:0]         m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic [2:0]         m_tdest;
  logic               m_tready;

  // master is the arbiter side; slave is the SURF sources plus the event framer
  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tdest
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tdest
  );
endinterface

// File: rtl/surf_frame_arbiter.sv
// rtl/surf_frame_arbiter.sv - per-frame round-robin merge of SURF streams with length watchdog
module surf_frame_arbiter #(
  parameter int          NSURF         = 7,
  parameter logic [15:0] MAX_FRAME_LEN = 16'd49152
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rstn_i,
  input  logic [NSURF-1:0]     enable_i,
  surf_frame_arbiter_if.master bus,
  output logic [2:0]           grant_o,
  output logic                 busy_o,
  output logic                 overlong_o,
  output logic [2:0]           overlong_src_o
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, last_q, pick;
  logic             pick_valid;
  logic [15:0]      count_q;
  logic             overlong_q;
  logic [2:0]       overlong_src_q;
  logic [NSURF-1:0] req;
  logic             sel_valid, sel_last, at_max, beat, truncate;

  assign req       = bus.s_tvalid & enable_i;
  assign sel_valid = bus.s_tvalid[grant_q];
  assign sel_last  = bus.s_tlast[grant_q];
  assign at_max    = (count_q == MAX_FRAME_LEN - 16'd1);

  // Scan from the highest offset down so the nearest requester after last_q wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NSURF; k >= 1; k--) begin
      int c;
      c = int'(last_q) + k;
      if (c >= NSURF) c = c - NSURF;
      if (req[c[2:0]]) begin
        pick       = c[2:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.s_tready = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tdata  = bus.s_tdata[{grant_q, 3'b000} +: 8];
    bus.m_tdest  = grant_q;
    beat         = 1'b0;
    truncate     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = GRANT;
      end
      GRANT: begin
        bus.s_tready[grant_q] = bus.m_tready;
        bus.m_tvalid          = sel_valid;
        bus.m_tlast           = sel_valid & (sel_last | at_max);
        beat                  = sel_valid & bus.m_tready;
        truncate              = beat & at_max & ~sel_last;
        if (beat && sel_last) state_d = IDLE;
        else if (truncate)    state_d = DRAIN;
      end
      DRAIN: begin
        // Swallow the rest of a runaway frame so the lane is clean for its next turn.
        bus.s_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      grant_q        <= '0;
      last_q         <= 3'(NSURF - 1);
      count_q        <= '0;
      overlong_q     <= 1'b0;
      overlong_src_q <= '0;
    end else begin
      overlong_q <= truncate;
      if (state_q == IDLE && pick_valid) begin
        grant_q <= pick;
        last_q  <= pick;
        count_q <= '0;
      end
      if (beat && count_q != 16'hffff) count_q <= count_q + 16'd1;
      if (truncate) overlong_src_q <= grant_q;
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign overlong_o     = overlong_q;
  assign overlong_src_o = overlong_src_q;

endmodule

// File: tb/tb_surf_frame_arbiter.sv
// tb/tb_surf_frame_arbiter.sv - bench for surf_frame_arbiter
module tb_surf_frame_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  enable;
  logic [55:0] s_tdata;
  logic [6:0]  s_tvalid, s_tlast;
  logic        m_tready;
  bit          sel;
  bit          bp;

  always #5 clk = ~clk;

  surf_frame_arbiter_if #(.NSURF(7)) ia ();
  surf_frame_arbiter_if #(.NSURF(7)) ib ();

  assign ia.s_tdata  = s_tdata;
  assign ia.s_tvalid = s_tvalid;
  assign ia.s_tlast  = s_tlast;
  assign ia.m_tready = m_tready;
  assign ib.s_tdata  = s_tdata;
  assign ib.s_tvalid = s_tvalid;
  assign ib.s_tlast  = s_tlast;
  assign ib.m_tready = m_tready;

  logic [2:0] grant_a, grant_b, osrc_a, osrc_b;
  logic       busy_a, busy_b, ovl_a, ovl_b;

  surf_frame_arbiter #(.NSURF(7), .MAX_FRAME_LEN(16'd49152)) dut_a (
    .sysclk_i(clk), .sysclk_rstn_i(rstn), .enable_i(enable), .bus(ia),
    .grant_o(grant_a), .busy_o(busy_a), .overlong_o(ovl_a), .overlong_src_o(osrc_a)
  );

  surf_frame_arbiter #(.NSURF(7), .MAX_FRAME_LEN(16'd8)) dut_b (
    .sysclk_i(clk), .sysclk_rstn_i(rstn), .enable_i(enable), .bus(ib),
    .grant_o(grant_b), .busy_o(busy_b), .overlong_o(ovl_b), .overlong_src_o(osrc_b)
  );

  wire [6:0] o_rdy   = sel ? ib.s_tready : ia.s_tready;
  wire [7:0] o_data  = sel ? ib.m_tdata  : ia.m_tdata;
  wire       o_vld   = sel ? ib.m_tvalid : ia.m_tvalid;
  wire       o_last  = sel ? ib.m_tlast  : ia.m_tlast;
  wire [2:0] o_dest  = sel ? ib.m_tdest  : ia.m_tdest;
  wire [2:0] o_grant = sel ? grant_b : grant_a;
  wire [2:0] o_osrc  = sel ? osrc_b  : osrc_a;
  wire       o_busy  = sel ? busy_b  : busy_a;
  wire       o_ovl   = sel ? ovl_b   : ovl_a;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] dest;
  } beat_t;

  typedef struct {
    bit         sel;
    logic [6:0] en;
    int         lane;
    int         len;
    bit         bp;
    int         exp_n;
    int         exp_ovl;
    int         nlane;
    int         nlen;
  } vec_t;

  beat_t      exp_q[$];
  logic [8:0] lane_buf [0:6][0:127];
  int         lane_head [0:6];
  int         lane_len  [0:6];
  int         n_tests = 0, n_fail = 0;
  int         ovl_cnt, beat_cnt, own_lane;
  bit         chk_others;
  logic       last_vld;
  vec_t       vt [0:6];

  function automatic void chk(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  task automatic load_frame(int lane, int len, int base);
    for (int k = 0; k < len; k++) begin
      lane_buf[lane][lane_len[lane]] = {(k == len - 1), 8'(base + k)};
      lane_len[lane]++;
    end
  endtask

  task automatic push_exp(int lane, int n, int base);
    for (int k = 0; k < n; k++) exp_q.push_back({8'(base + k), (k == n - 1), 3'(lane)});
  endtask

  task automatic drive();
    for (int i = 0; i < 7; i++) begin
      if (lane_head[i] < lane_len[i]) begin
        s_tvalid[i] = 1'b1;
        {s_tlast[i], s_tdata[8*i +: 8]} = lane_buf[i][lane_head[i]];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
    m_tready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
  endtask

  task automatic check_beat();
    beat_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_beat: got data %0h dest %0d, none expected", o_data, o_dest);
    end else begin
      e = exp_q.pop_front();
      chk("m_tdata", int'(o_data), int'(e.data));
      chk("m_tlast", int'(o_last), int'(e.last));
      chk("m_tdest", int'(o_dest), int'(e.dest));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    last_vld = o_vld;
    if (o_ovl) ovl_cnt++;
    if (chk_others) chk("other_tready", int'(o_rdy & ~(7'd1 << own_lane)), 0);
    if (o_vld && m_tready) begin
      beat_cnt++;
      check_beat();
    end
    for (int i = 0; i < 7; i++) if (s_tvalid[i] && o_rdy[i]) lane_head[i]++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until(int budget, logic [6:0] mask);
    int c;
    bit done;
    c    = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      done = (exp_q.size() == 0);
      for (int i = 0; i < 7; i++) if (mask[i] && lane_head[i] < lane_len[i]) done = 1'b0;
      if (!done) begin
        cycle();
        c++;
      end
    end
    chk("completion", int'(done), 1);
    repeat (3) cycle();
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    enable   = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    bp       = 1'b0;
    m_tready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      lane_head[i] = 0;
      lane_len[i]  = 0;
    end
    ovl_cnt    = 0;
    beat_cnt   = 0;
    chk_others = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 7'h04, 2,   5, 1'b0,   5, 0, -1, 0};
    vt[1] = '{1'b0, 7'h10, 4, 100, 1'b1, 100, 0, -1, 0};
    vt[2] = '{1'b1, 7'h42, 1,  12, 1'b0,   8, 1,  6, 3};
    vt[3] = '{1'b1, 7'h02, 1,   8, 1'b0,   8, 0, -1, 0};
    vt[4] = '{1'b1, 7'h01, 0,   9, 1'b0,   8, 1, -1, 0};
    vt[5] = '{1'b1, 7'h7f, 3,   1, 1'b0,   1, 0, -1, 0};
    vt[6] = '{1'b0, 7'h7f, 0,   7, 1'b0,   7, 0,  5, 2};

    // reset state on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      apply_reset();
      @(negedge clk);
      chk("rst_s_tready", int'(o_rdy), 0);
      chk("rst_m_tvalid", int'(o_vld), 0);
      chk("rst_m_tlast", int'(o_last), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_grant", int'(o_grant), 0);
      chk("rst_overlong", int'(o_ovl), 0);
      chk("rst_overlong_src", int'(o_osrc), 0);
    end

    for (int t = 0; t < 7; t++) begin
      sel = vt[t].sel;
      apply_reset();
      enable = vt[t].en;
      bp     = vt[t].bp;
      load_frame(vt[t].lane, vt[t].len, 1);
      push_exp(vt[t].lane, vt[t].exp_n, 1);
      if (vt[t].nlane >= 0) begin
        load_frame(vt[t].nlane, vt[t].nlen, 8'h80);
        push_exp(vt[t].nlane, vt[t].nlen, 8'h80);
      end
      chk_others = vt[t].bp;
      own_lane   = vt[t].lane;
      drive();
      run_until(3000, 7'h7f);
      chk_others = 1'b0;
      chk("overlong_pulses", ovl_cnt, vt[t].exp_ovl);
      if (vt[t].exp_ovl != 0) chk("overlong_src", int'(o_osrc), vt[t].lane);
      chk("busy_end", int'(o_busy), 0);
    end

    // arbitration latency and one-cycle frame gap
    sel = 1'b0;
    apply_reset();
    enable = 7'h04;
    load_frame(2, 2, 1);
    load_frame(2, 2, 8'h10);
    push_exp(2, 2, 1);
    push_exp(2, 2, 8'h10);
    drive();
    begin
      bit exp_v [0:6];
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 7; c++) begin
        cycle();
        chk("gap_m_tvalid", int'(last_vld), int'(exp_v[c]));
      end
    end
    chk("gap_grant", int'(o_grant), 2);

    // round robin: every lane sends two 3-byte frames
    apply_reset();
    enable = 7'h7f;
    for (int i = 0; i < 7; i++) begin
      load_frame(i, 3, i * 16);
      load_frame(i, 3, i * 16 + 8);
    end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 7; i++) push_exp(i, 3, i * 16 + f * 8);
    drive();
    run_until(500, 7'h7f);
    chk("rr_beats", beat_cnt, 42);

    // masked lane is never granted
    apply_reset();
    enable = 7'h77;
    load_frame(3, 4, 8'h30);
    load_frame(1, 3, 8'h10);
    push_exp(1, 3, 8'h10);
    drive();
    run_until(200, 7'h77);
    repeat (5) cycle();
    chk("masked_consumed", lane_head[3], 0);
    chk("masked_busy", int'(o_busy), 0);

    // enable drop mid-frame does not abort it
    apply_reset();
    enable = 7'h08;
    load_frame(3, 6, 8'h50);
    push_exp(3, 6, 8'h50);
    drive();
    repeat (3) cycle();
    enable = 7'h00;
    run_until(200, 7'h7f);
    chk("en_drop_consumed", lane_head[3], 6);

    // reset mid-frame, then first grant restarts at SURF 0
    apply_reset();
    enable = 7'h20;
    load_frame(5, 20, 1);
    push_exp(5, 20, 1);
    drive();
    repeat (4) cycle();
    chk("pre_rst_busy", int'(o_busy), 1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_m_tvalid", int'(o_vld), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_s_tready", int'(o_rdy), 0);
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      lane_head[i] = 0;
      lane_len[i]  = 0;
    end
    for (int i = 0; i < 7; i++) begin
      load_frame(i, 1, 8'h40 + i);
      push_exp(i, 1, 8'h40 + i);
    end
    enable = 7'h7f;
    rstn   = 1'b1;
    drive();
    run_until(200, 7'h7f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
